// File: rtl/get_bit.sv
// get_bit: MSB-first bitstream reader for the ProRes slice decode path.
// Bytes from the slice source are packed into a left-aligned 64-bit shift
// buffer; entropy decoders pull 1..32-bit fields (consume or peek) and may
// realign the stream to the next byte boundary.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. in_ready and req_ready are combinational from registered state
//   (r_cnt) and the current inputs only; nothing depends on out_*. A stalled
//   requester keeps req_valid/req_size/req_peek stable until req_ready.
//   out_valid is a one-cycle pulse; out_val holds between pulses.
module get_bit #(
  parameter int BUF_BITS  = 64,
  parameter int MAX_FIELD = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  input  logic        req_valid,
  input  logic [5:0]  req_size,
  input  logic        req_peek,
  output logic        req_ready,
  input  logic        align,
  output logic        out_valid,
  output logic [31:0] out_val,
  output logic [6:0]  bits_avail,
  output logic [31:0] bit_offset,
  output logic        error
);

  // Registered state
  logic [BUF_BITS-1:0] r_buf;
  logic [6:0]          r_cnt;
  logic [31:0]         r_bit_offset;
  logic                r_out_valid;
  logic [31:0]         r_out_val;
  logic                r_error;

  // Combinational datapath
  logic                w_size_ok;
  logic                w_enough;
  logic                w_push;
  logic                w_accept;
  logic [6:0]          w_consume;
  logic [6:0]          w_cnt_after;
  logic [6:0]          w_cnt_next;
  logic [BUF_BITS-1:0] w_buf_shift;
  logic [BUF_BITS-1:0] w_byte_ext;
  logic [BUF_BITS-1:0] w_buf_next;
  logic [5:0]          w_field_shift;
  logic [31:0]         w_field;

  // Request legality, readiness and the handshake results
  always_comb begin
    w_size_ok = (req_size != 6'd0) && ({1'b0, req_size} <= 7'(MAX_FIELD));
    w_enough  = (r_cnt >= {1'b0, req_size});
    in_ready  = !reset && (r_cnt <= 7'(BUF_BITS - 8));
    req_ready = !reset && !align && req_valid && w_size_ok && w_enough;
    w_push    = in_valid && in_ready;
    w_accept  = req_ready;
  end

  // Bits removed from the head this cycle: align drops the partial byte,
  // otherwise a consuming request drops its field; peeks remove nothing.
  always_comb begin
    w_consume = 7'd0;
    if (align) begin
      w_consume = {4'd0, r_cnt[2:0]};
    end else if (w_accept && !req_peek) begin
      w_consume = {1'b0, req_size};
    end
  end

  // Next buffer contents: shift out consumed bits, then append the new
  // byte directly behind whatever valid bits remain.
  always_comb begin
    w_cnt_after = r_cnt - w_consume;
    w_buf_shift = r_buf << w_consume;
    w_byte_ext  = {in_byte, {(BUF_BITS - 8){1'b0}}} >> w_cnt_after;
    w_buf_next  = w_buf_shift;
    w_cnt_next  = w_cnt_after;
    if (w_push) begin
      w_buf_next = w_buf_shift | w_byte_ext;
      w_cnt_next = w_cnt_after + 7'd8;
    end
  end

  // Field extraction from the top of the buffer, right-aligned
  always_comb begin
    w_field_shift = 6'(MAX_FIELD) - req_size;
    w_field       = r_buf[BUF_BITS-1 -: MAX_FIELD] >> w_field_shift;
  end

  // Shift buffer, valid-bit count and running bit offset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_buf        <= '0;
      r_cnt        <= 7'd0;
      r_bit_offset <= 32'd0;
    end else begin
      r_buf        <= w_buf_next;
      r_cnt        <= w_cnt_next;
      r_bit_offset <= r_bit_offset + 32'(w_consume);
    end
  end

  // Result register: pulse on accept, value held otherwise
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_val   <= 32'd0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_val <= w_field;
      end
    end
  end

  // Sticky flag for an offered request with an illegal size
  always_ff @(posedge clock) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if (req_valid && !w_size_ok) begin
      r_error <= 1'b1;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_val    = r_out_val;
  assign bits_avail = r_cnt;
  assign bit_offset = r_bit_offset;
  assign error      = r_error;

endmodule

// File: tb/tb_get_bit.sv
// Bench for get_bit: a bit-queue reference model predicts readiness, state
// and every returned field; fields go through an expected queue popped when
// the DUT pulses out_valid.
module tb_get_bit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        req_valid;
  logic [5:0]  req_size;
  logic        req_peek;
  logic        req_ready;
  logic        align;
  logic        out_valid;
  logic [31:0] out_val;
  logic [6:0]  bits_avail;
  logic [31:0] bit_offset;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  bit          mdl_q[$];
  logic [31:0] mdl_off  = 32'd0;
  logic        mdl_err  = 1'b0;
  logic [31:0] last_val = 32'd0;
  bit          mon_en   = 1'b0;

  get_bit dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .req_valid  (req_valid),
    .req_size   (req_size),
    .req_peek   (req_peek),
    .req_ready  (req_ready),
    .align      (align),
    .out_valid  (out_valid),
    .out_val    (out_val),
    .bits_avail (bits_avail),
    .bit_offset (bit_offset),
    .error      (error)
  );

  // Clock
  always #5 clock = ~clock;

  // Result monitor: pops the scoreboard on each out_valid pulse
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stray_out_valid: out_val=%h with no result expected", out_val);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (out_val !== e) begin
            errors++;
            $display("FAIL out_val: got %h expected %h", out_val, e);
          end
          last_val = e;
        end
      end else if (out_valid !== 1'b0 || out_val !== last_val) begin
        errors++;
        $display("FAIL out_hold: out_valid=%b out_val=%h expected 0/%h", out_valid, out_val, last_val);
      end
    end
  end

  // One clock of stimulus; model predicts readiness and updates at the edge
  task automatic step(input logic rst, input logic pv, input logic [7:0] pb,
                      input logic rv, input logic [5:0] rs, input logic rp,
                      input logic al, output logic accepted);
    logic        exp_ir, exp_rr, size_ok;
    int          cnt, drop;
    logic [31:0] f;
    reset = rst; in_valid = pv; in_byte = pb;
    req_valid = rv; req_size = rs; req_peek = rp; align = al;
    @(negedge clock);
    cnt     = mdl_q.size();
    size_ok = (rs >= 6'd1) && (rs <= 6'd32);
    exp_ir  = !rst && (cnt <= 56);
    exp_rr  = !rst && !al && rv && size_ok && (cnt >= int'(rs));
    f = 32'd0;
    if (exp_rr) for (int i = 0; i < int'(rs); i++) f = {f[30:0], mdl_q[i]};
    checks += 5;
    if (in_ready !== exp_ir) begin errors++; $display("FAIL in_ready: got %b expected %b", in_ready, exp_ir); end
    if (req_ready !== exp_rr) begin errors++; $display("FAIL req_ready: got %b expected %b", req_ready, exp_rr); end
    if (bits_avail !== 7'(cnt)) begin errors++; $display("FAIL bits_avail: got %0d expected %0d", bits_avail, cnt); end
    if (bit_offset !== mdl_off) begin errors++; $display("FAIL bit_offset: got %0d expected %0d", bit_offset, mdl_off); end
    if (error !== mdl_err) begin errors++; $display("FAIL error_flag: got %b expected %b", error, mdl_err); end
    @(posedge clock);
    accepted = exp_rr;
    if (rst) begin
      mdl_q.delete(); exp_q.delete();
      mdl_off = 32'd0; mdl_err = 1'b0; last_val = 32'd0;
    end else begin
      if (al) begin
        drop = cnt % 8;
        repeat (drop) void'(mdl_q.pop_front());
        mdl_off += 32'(drop);
      end else if (exp_rr) begin
        exp_q.push_back(f);
        if (!rp) begin
          repeat (int'(rs)) void'(mdl_q.pop_front());
          mdl_off += 32'(rs);
        end
      end
      if (pv && exp_ir) for (int i = 7; i >= 0; i--) mdl_q.push_back(pb[i]);
      if (rv && !size_ok) mdl_err = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    repeat (n) step(0, 0, 8'h00, 0, 6'd0, 0, 0, a);
  endtask

  task automatic push(input logic [7:0] b);
    logic a;
    step(0, 1, b, 0, 6'd0, 0, 0, a);
  endtask

  task automatic rd(input logic [5:0] n, input logic pk);
    logic a;
    step(0, 0, 8'h00, 1, n, pk, 0, a);
  endtask

  task automatic do_reset();
    logic a;
    step(1, 0, 8'h00, 0, 6'd0, 0, 0, a);
    step(1, 0, 8'h00, 0, 6'd0, 0, 0, a);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; in_byte = 0; req_valid = 0;
    req_size = 0; req_peek = 0; align = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_val", out_val, 0);
    chk("rst_bits_avail", 32'(bits_avail), 0);
    chk("rst_bit_offset", bit_offset, 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    req_valid = 1; req_size = 6'd1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    req_valid = 0;
    mon_en = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_read_basic();
    do_reset();
    push(8'hA5); push(8'h3C);
    rd(6'd4, 0); rd(6'd12, 0);
    idle(1);
    chk("basic_last_val", last_val, 32'h53C);
    chk("basic_bit_offset", bit_offset, 32'd16);
    chk("basic_bits_avail", 32'(bits_avail), 0);
  endtask

  task automatic test_peek();
    do_reset();
    push(8'hF0);
    rd(6'd8, 1);
    chk("peek_bits_avail", 32'(bits_avail), 8);
    rd(6'd3, 0);
    idle(1);
    chk("peek_read_val", last_val, 32'h7);
    chk("peek_bit_offset", bit_offset, 32'd3);
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) push(8'($urandom_range(0, 255)));
    chk("full_bits_avail", 32'(bits_avail), 64);
    chk("full_in_ready", 32'(in_ready), 0);
    push(8'h55);
    rd(6'd8, 0);
    chk("full_in_ready_after", 32'(in_ready), 1);
    rd(6'd32, 0); rd(6'd24, 0);
    idle(1);
  endtask

  task automatic test_push_consume_56();
    logic a;
    do_reset();
    for (int i = 0; i < 7; i++) push(8'($urandom_range(0, 255)));
    chk("p56_bits_avail", 32'(bits_avail), 56);
    step(0, 1, 8'h96, 1, 6'd5, 0, 0, a);
    chk("p56_accept", 32'(a), 1);
    chk("p56_bits_after", 32'(bits_avail), 59);
    rd(6'd32, 0); rd(6'd19, 0); rd(6'd8, 0);
    idle(1);
    chk("p56_appended_byte", last_val, 32'h96);
  endtask

  task automatic test_align();
    logic a;
    do_reset();
    push(8'hC3); push(8'h5A);
    rd(6'd3, 0);
    step(0, 0, 8'h00, 1, 6'd1, 0, 1, a);
    chk("align_blocks_req", 32'(a), 0);
    chk("align_bits_avail", 32'(bits_avail), 8);
    chk("align_bit_offset", bit_offset, 32'd8);
    step(0, 0, 8'h00, 1, 6'd1, 0, 0, a);
    chk("align_req_next", 32'(a), 1);
    rd(6'd7, 0);
    step(0, 0, 8'h00, 0, 6'd0, 0, 1, a);
    chk("align_noop_offset", bit_offset, 32'd16);
    push(8'h81);
    rd(6'd2, 0);
    step(0, 1, 8'hE7, 0, 6'd0, 0, 1, a);
    chk("align_push_bits", 32'(bits_avail), 8);
    rd(6'd8, 0);
    idle(1);
    chk("align_push_val", last_val, 32'hE7);
  endtask

  task automatic test_illegal();
    do_reset();
    push(8'hFF);
    rd(6'd0, 0);
    chk("illegal0_error", 32'(error), 1);
    rd(6'd33, 0);
    rd(6'd63, 1);
    idle(2);
    chk("illegal_sticky", 32'(error), 1);
    rd(6'd8, 0);
    idle(1);
  endtask

  task automatic test_mid_reset();
    logic a;
    do_reset();
    for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 255)));
    rd(6'd8, 0);
    step(1, 1, 8'h12, 1, 6'd8, 0, 0, a);
    chk("mrst_out_val", out_val, 0);
    chk("mrst_bits_avail", 32'(bits_avail), 0);
    chk("mrst_bit_offset", bit_offset, 0);
    push(8'h3E);
    rd(6'd16, 0); rd(6'd16, 0);
    step(1, 0, 8'h00, 1, 6'd16, 0, 0, a);
    chk("mrst_stall_bits", 32'(bits_avail), 0);
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic       a, pv, rv, pk, al;
    logic [5:0] sz;
    do_reset();
    rv = 0; sz = 6'd1; pk = 0;
    for (int i = 0; i < 400; i++) begin
      if (!rv) begin
        rv = ($urandom_range(0, 9) != 0);
        sz = 6'($urandom_range(1, 32));
        pk = ($urandom_range(0, 5) == 0);
      end
      pv = ($urandom_range(0, 3) != 0);
      al = ($urandom_range(0, 15) == 0);
      step(0, pv, 8'($urandom_range(0, 255)), rv, sz, pk, al, a);
      if (a) rv = 0;
    end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_peek();
    test_full();
    test_push_consume_56();
    test_align();
    test_illegal();
    test_mid_reset();
    test_back_to_back();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) idle(1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results never produced, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/get_bit.md
# get_bit

Bitstream reader for the ProRes decode path and the receive-side counterpart of `set_bit`. It accepts the byte stream that `set_bit` emits, MSB-first, and keeps it in a 64-bit shift buffer. It returns variable-length fields of 1–32 bits on request, either consuming them or peeking without consuming. It also supports alignment to the next byte boundary, the inverse of `set_bit`'s flush. Sits between the slice byte source and the DC/AC entropy decoders.

## Interface
- `BUF_BITS`, 64: shift-buffer depth in bits; fixed at 64 for this revision.
- `MAX_FIELD`, 32: largest field size a single request may ask for.

Ports:
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  a byte is offered on `in_byte`.
- `in_byte`  in  8  next stream byte; bit 7 is the first bit in the stream.
- `in_ready`  out  1  a byte can be accepted this cycle.
- `req_valid`  in  1  a field request is offered.
- `req_size`  in  6  field size in bits; legal range 1..32.
- `req_peek`  in  1  1 = return the field without consuming it.
- `req_ready`  out  1  the request is accepted this cycle.
- `align`  in  1  discard bits up to the next byte boundary.
- `out_valid`  out  1  single-cycle pulse marking a valid result.
- `out_val`  out  32  the field, right-aligned, with upper bits zero.
- `bits_avail`  out  7  number of valid bits in the buffer (0..64).
- `bit_offset`  out  32  total bits consumed since reset.
- `error`  out  1  sticky flag for an illegal `req_size`.

## Operation
- State:
  - `buf[63:0]` holds valid bits left-aligned; the next stream bit is `buf[63]`.
  - `cnt` holds the valid-bit count and drives `bits_avail`.
- Byte push, when `in_valid && in_ready`:
  - The byte is written at bit positions `[63-cnt' : 56-cnt']`.
  - `cnt'` is the count after this cycle's consume.
- `in_ready = !reset && cnt <= 56`. It uses the current `cnt`, not the post-consume count.
- `req_ready = !reset && !align && req_valid && req_size in 1..32 && cnt >= req_size`.
- Accepted request:
  - Next cycle, `out_valid` = 1 and `out_val` = `buf[63 -: req_size]`, zero-extended.
  - If `req_peek` = 0, the buffer shifts left by `req_size`, `cnt` drops by `req_size`, and `bit_offset` rises by `req_size`.
  - If `req_peek` = 1, the buffer, `cnt` and `bit_offset` are all unchanged.
- Insufficient bits (`cnt < req_size`):
  - The request stalls with `req_ready` = 0.
  - The requester holds the request stable until it is accepted.
- Illegal size (`req_size` = 0 or > 32, while `req_valid` is high):
  - The request is never accepted.
  - `error` sets and stays set until reset.
- Align:
  - Drops `cnt mod 8` bits from the top of the buffer.
  - `bit_offset` rises by the same amount.
  - Align takes precedence: no request is accepted in the same cycle.
  - A byte push in the same cycle is still allowed.
  - Align at `cnt mod 8` = 0 is a no-op.
- Same cycle push + consume: `cnt_next = cnt - consumed + 8`. This never exceeds 64, given the `in_ready` rule.
- Arithmetic:
  - `cnt` is 7-bit unsigned.
  - `bit_offset` is 32-bit and wraps modulo 2^32 with no flag.

## Timing
- Reset values:
  - `out_valid`=0, `out_val`=0, `bits_avail`=0, `bit_offset`=0, `error`=0, `buf`=0.
  - `in_ready`=0 and `req_ready`=0 while `reset` is high.
- Reset applied mid-operation:
  - All buffered data and any pending result are dropped on that edge.
  - No `out_valid` is produced after reset for a request accepted before it.
- Latency:
  - Request accept to `out_valid`: 1 cycle.
  - A byte accepted in cycle N is usable by requests from cycle N+1.
- Throughput:
  - One request per cycle, back-to-back.
  - One byte per cycle in parallel with requests.
- `out_val` holds its last value when `out_valid` = 0.
- `req_ready` and `in_ready` are combinational from registered `cnt` and the inputs; there is no combinational path from `out_*`.

## Test plan
- Push 0xA5, 0x3C; read 4, then read 12 -> `out_val` = 0xA, then 0x53C; `bit_offset` = 16; `bits_avail` = 0.
- Push 0xF0; peek 8 -> 0xF0 with `bits_avail` still 8; read 3 -> 0x7; `bit_offset` = 3.
- Push 8 bytes -> `bits_avail` = 64 and `in_ready` = 0; read 8 -> `in_ready` = 1 on the next cycle.
- With `cnt` = 56 and one more byte offered: a read of 5 in the same cycle is accepted and the byte is taken (`in_ready` = 1 at 56); next cycle `bits_avail` = 59 and the appended byte sits directly behind the remaining 51 bits.
- After pushing 2 bytes and reading 3 bits, assert `align` together with a 1-bit request -> `bits_avail` = 8, `bit_offset` = 8, and the request is accepted only on the next cycle.
- `req_size` = 0, then 33 -> no `out_valid` and `error` = 1 and sticky; assert `reset` mid-stream with a request in flight -> all outputs return to their reset values and no stray `out_valid` appears.
